ifetch: RTL

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch_if.sv | 24 ++
 rtl/ifetch.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ifetch_if.sv
// Fetch-stage bundle: icache request/response, execute redirect and decode handshake.
`timescale 1ns/1ps
interface ifetch_if;
    logic [31:0] icache_rdaddr;
    logic        icache_rdreq;
    logic [31:0] icache_dataout;
    logic        icache_valid;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output icache_rdaddr, icache_rdreq, instr_out, pc_out, instr_valid,
        input  icache_dataout, icache_valid, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  icache_rdaddr, icache_rdreq, instr_out, pc_out, instr_valid,
        output icache_dataout, icache_valid, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch: one icache request in flight, response lands in output storage the cycle it arrives.
// Backpressure holds off new requests when storage is full; IFETCH_SKIDBUF_EN selects a 2-entry skid FIFO.
`timescale 1ns/1ps
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic     clk,
    input  logic     reset_n,
    ifetch_if.master bus
);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [31:0] BOOT_PC = {RESET_PC[31:2], 2'b00};

    logic [1:0]  state;
    logic [31:0] pc;
    logic        pending;
    logic        redirect;
    logic        out_vld;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        pop;
    logic        can_issue;
    logic        rdreq;
    logic        wr_en;

    assign redirect = bus.redirect_valid;
    assign pop      = out_vld && bus.instr_ready;

    // While waiting, the request is held; it drops in the response cycle so the
    // icache never sees a second request for the same address.
    assign rdreq = (state == S_REQ) && !redirect &&
                   (pending ? !bus.icache_valid : can_issue);
    assign wr_en = (state == S_REQ) && !redirect && pending && bus.icache_valid;

    assign bus.icache_rdaddr = pc;
    assign bus.icache_rdreq  = rdreq;
    assign bus.instr_valid   = out_vld;
    assign bus.instr_out     = out_instr;
    assign bus.pc_out        = out_pc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_BOOT;
            pc      <= BOOT_PC;
            pending <= 1'b0;
        end else if (redirect) begin
            state   <= S_FLUSH;
            pc      <= {bus.redirect_pc[31:2], 2'b00};
            pending <= 1'b0;
        end else begin
            case (state)
                S_BOOT: begin
                    state <= S_REQ;
                    pc    <= BOOT_PC;
                end
                S_REQ: begin
                    if (wr_en) begin
                        pc      <= pc + 32'd4;
                        pending <= 1'b0;
                    end else if (rdreq) begin
                        pending <= 1'b1;
                    end
                end
                S_FLUSH: state <= S_REQ;
                default: state <= S_BOOT;
            endcase
        end
    end

`ifdef IFETCH_SKIDBUF_EN
    logic [31:0] buf_instr [2];
    logic [31:0] buf_pc    [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    assign out_vld   = (count != 2'd0);
    assign out_instr = buf_instr[rd_ptr];
    assign out_pc    = buf_pc[rd_ptr];
    // A slot being drained this cycle is free by the time the response returns.
    assign can_issue = (count != 2'd2) || pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_instr[0] <= '0;
            buf_instr[1] <= '0;
            buf_pc[0]    <= '0;
            buf_pc[1]    <= '0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            count        <= 2'd0;
        end else if (redirect) begin
            rd_ptr <= wr_ptr;
            count  <= 2'd0;
        end else begin
            if (wr_en) begin
                buf_instr[wr_ptr] <= bus.icache_dataout;
                buf_pc[wr_ptr]    <= pc;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({wr_en, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
`else
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;
    logic        full;

    assign out_vld   = full;
    assign out_instr = buf_instr;
    assign out_pc    = buf_pc;
    assign can_issue = !full || pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_instr <= '0;
            buf_pc    <= '0;
            full      <= 1'b0;
        end else if (redirect) begin
            full <= 1'b0;
        end else if (wr_en) begin
            buf_instr <= bus.icache_dataout;
            buf_pc    <= pc;
            full      <= 1'b1;
        end else if (pop) begin
            full <= 1'b0;
        end
    end
`endif

endmodule
